// File: rtl/secuenciador_compuertas.sv
// secuenciador_compuertas
// Self-test sequencer for the basic gate unit (AND, OR, NOT of A).
// Drives all four {A,B} combinations, waits a settle window for each,
// samples the gate outputs into three truth tables and compares them
// against the golden tables, reporting through a start/busy/done handshake.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start, gate inputs parked at 00
// APPLY  | driving combination idx, settle window running
// SAMPLE | last cycle of combination idx, outputs latched on exit
// CHECK  | compare sampled tables against golden, build verdict
// DONE   | one-cycle done pulse, results stay valid afterwards

module secuenciador_compuertas #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       y_and,
    input  logic       y_or,
    input  logic       y_not,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       err_valid,
    output logic [1:0] err_idx,
    output logic [3:0] tabla_and,
    output logic [3:0] tabla_or,
    output logic [3:0] tabla_not
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SAMPLE,
        CHECK,
        DONE
    } state_t;

    // Bit i of each table corresponds to combination i = {A,B}.
    localparam logic [3:0] GOLD_AND = 4'b1000;
    localparam logic [3:0] GOLD_OR  = 4'b1110;
    localparam logic [3:0] GOLD_NOT = 4'b0011;

    // The settle counter counts up from 0; the last APPLY cycle is SETTLE_CYCLES-1.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [1:0] idx;
    logic [3:0] settle_cnt;

    logic [3:0] mism;
    logic       all_match;
    logic [1:0] first_bad;

    // Per-combination mismatch vector and the lowest failing combination.
    always_comb begin
        mism      = (tabla_and ^ GOLD_AND) | (tabla_or ^ GOLD_OR) | (tabla_not ^ GOLD_NOT);
        all_match = (mism == 4'b0000);
        first_bad = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mism[i]) begin
                first_bad = 2'(i);
            end
        end
    end

    // Sequencer FSM with registered gate drives, handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 2'd0;
            settle_cnt <= 4'd0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_valid  <= 1'b0;
            err_idx    <= 2'd0;
            tabla_and  <= 4'd0;
            tabla_or   <= 4'd0;
            tabla_not  <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    a_out <= 1'b0;
                    b_out <= 1'b0;
                    busy  <= 1'b0;
                    if (start) begin
                        state      <= APPLY;
                        idx        <= 2'd0;
                        settle_cnt <= 4'd0;
                        busy       <= 1'b1;
                        // Results of the previous run are discarded on acceptance.
                        pass       <= 1'b0;
                        err_valid  <= 1'b0;
                        err_idx    <= 2'd0;
                        tabla_and  <= 4'd0;
                        tabla_or   <= 4'd0;
                        tabla_not  <= 4'd0;
                    end
                end

                APPLY: begin
                    // Combination idx is already on a_out/b_out since state entry.
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end

                SAMPLE: begin
                    tabla_and[idx] <= y_and;
                    tabla_or[idx]  <= y_or;
                    tabla_not[idx] <= y_not;
                    if (idx == 2'd3) begin
                        state <= CHECK;
                        a_out <= 1'b0;
                        b_out <= 1'b0;
                    end else begin
                        state           <= APPLY;
                        idx             <= idx + 2'd1;
                        settle_cnt      <= 4'd0;
                        {a_out, b_out}  <= idx + 2'd1;
                    end
                end

                CHECK: begin
                    pass      <= all_match;
                    err_valid <= ~all_match;
                    err_idx   <= all_match ? 2'd0 : first_bad;
                    state     <= DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end

                DONE: begin
                    // start is ignored here; a held start is taken in the next IDLE cycle.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    a_out <= 1'b0;
                    b_out <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_compuertas.sv
module tb_secuenciador_compuertas;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start1;
    logic       fault;

    logic       a_out, b_out, y_and, y_or, y_not;
    logic       busy, done, pass, err_valid;
    logic [1:0] err_idx;
    logic [3:0] tabla_and, tabla_or, tabla_not;

    logic       a1, b1, y_and1, y_or1, y_not1;
    logic       busy1, done1, pass1, err_valid1;
    logic [1:0] err_idx1;
    logic [3:0] tabla_and1, tabla_or1, tabla_not1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Gate unit models: dut0 can be given a faulty AND wired to OR.
    assign y_and  = fault ? (a_out | b_out) : (a_out & b_out);
    assign y_or   = a_out | b_out;
    assign y_not  = ~a_out;
    assign y_and1 = a1 & b1;
    assign y_or1  = a1 | b1;
    assign y_not1 = ~a1;

    secuenciador_compuertas #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_out(a_out), .b_out(b_out),
        .y_and(y_and), .y_or(y_or), .y_not(y_not),
        .busy(busy), .done(done), .pass(pass),
        .err_valid(err_valid), .err_idx(err_idx),
        .tabla_and(tabla_and), .tabla_or(tabla_or), .tabla_not(tabla_not)
    );

    secuenciador_compuertas #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a_out(a1), .b_out(b1),
        .y_and(y_and1), .y_or(y_or1), .y_not(y_not1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_valid(err_valid1), .err_idx(err_idx1),
        .tabla_and(tabla_and1), .tabla_or(tabla_or1), .tabla_not(tabla_not1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One run of dut0 from IDLE; E1 is the edge that accepts start.
    task automatic full_run(input string tag, input bit poke, input bit exp_pass,
                            input logic [3:0] exp_and, input logic [1:0] exp_eidx);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (k > 1) tick();
            chk({tag, "_ab"}, {30'd0, a_out, b_out}, (k == 13) ? 32'd0 : 32'((k - 1) / 3));
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
            if (poke && k == 4) start = 1'b1;
            if (poke && k == 5) start = 1'b0;
        end
        tick();
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_pass"}, {31'd0, pass}, {31'd0, exp_pass});
        chk({tag, "_errv"}, {31'd0, err_valid}, {31'd0, ~exp_pass});
        chk({tag, "_eidx"}, {30'd0, err_idx}, {30'd0, exp_eidx});
        chk({tag, "_tand"}, {28'd0, tabla_and}, {28'd0, exp_and});
        chk({tag, "_tor"}, {28'd0, tabla_or}, 32'b1110);
        chk({tag, "_tnot"}, {28'd0, tabla_not}, 32'b0011);
        if (poke) start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_done_once"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        tick();
        chk({tag, "_no_restart"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hold_pass"}, {31'd0, pass}, {31'd0, exp_pass});
        chk({tag, "_hold_tand"}, {28'd0, tabla_and}, {28'd0, exp_and});
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b1;
        start1 = 1'b0;
        fault  = 1'b0;
        #2;
        chk("rst_async_busy", {31'd0, busy}, 32'd0);
        repeat (4) tick();
        chk("rst_hold_ab", {30'd0, a_out, b_out}, 32'd0);
        chk("rst_hold_busy", {31'd0, busy}, 32'd0);
        chk("rst_hold_done", {31'd0, done}, 32'd0);
        chk("rst_hold_tables", {20'd0, tabla_and, tabla_or, tabla_not}, 32'd0);
        chk("rst_hold_res", {28'd0, pass, err_valid, err_idx}, 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        full_run("good", 1'b0, 1'b1, 4'b1000, 2'd0);

        fault = 1'b1;
        full_run("fault", 1'b0, 1'b0, 4'b1110, 2'd1);
        fault = 1'b0;

        full_run("poke", 1'b1, 1'b1, 4'b1000, 2'd0);

        // Reset in the middle of combination 2.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("mid_ab_idx2", {30'd0, a_out, b_out}, 32'd2);
        chk("mid_tor_partial", {28'd0, tabla_or}, 32'b0010);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ab", {30'd0, a_out, b_out}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_tor", {28'd0, tabla_or}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        full_run("after_rst", 1'b0, 1'b1, 4'b1000, 2'd0);

        // SETTLE_CYCLES=1 instance: each combination held 2 cycles, done at E10.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) tick();
            chk("s1_ab", {30'd0, a1, b1}, (k == 9) ? 32'd0 : 32'((k - 1) / 2));
            chk("s1_busy", {31'd0, busy1}, 32'd1);
            chk("s1_nodone", {31'd0, done1}, 32'd0);
        end
        tick();
        chk("s1_done", {31'd0, done1}, 32'd1);
        chk("s1_pass", {30'd0, pass1, err_valid1}, 32'b10);
        chk("s1_eidx", {30'd0, err_idx1}, 32'd0);
        chk("s1_tables", {20'd0, tabla_and1, tabla_or1, tabla_not1}, 32'h8E3);
        tick();
        chk("s1_done_end", {31'd0, done1}, 32'd0);

        // start held high: back-to-back runs with one IDLE cycle between.
        start1 = 1'b1;
        tick();
        repeat (9) tick();
        chk("b2b_done1", {31'd0, done1}, 32'd1);
        tick();
        chk("b2b_idle_gap", {31'd0, busy1}, 32'd0);
        tick();
        chk("b2b_restart", {31'd0, busy1}, 32'd1);
        chk("b2b_cleared", {28'd0, tabla_and1}, 32'd0);
        start1 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
